// File: rtl/sca_blk_sched.sv
// Next-block write-port scheduler: captures four release paths into pending slots,
// arbitrates, and drives a SETUP/WRITE/HOLD transaction into the block allocator.
module sca_blk_sched #(
  parameter int RR        = 1,
  parameter int SETUP_CYC = 1,
  parameter int TMR       = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENA,
  input  logic [3:0]  REQ,
  input  logic [15:0] REQ_ADR,
  input  logic        CNT_CLR,
  output logic [3:0]  PATHSEL,
  output logic [3:0]  BADR,
  output logic        WRENA,
  output logic [3:0]  ACK,
  output logic [3:0]  PEND,
  output logic        BUSY,
  output logic [3:0]  OVF,
  output logic [7:0]  WR_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int CW = 10;

  function automatic logic [CW-1:0] vote(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  pend_q, pend_d;
  logic [CW-1:0] ctrl_q, ctrl_d;

  logic [1:0]  setup_cnt_q, setup_cnt_d;
  logic [3:0]  adr_q [4];
  logic [3:0]  pathsel_q, pathsel_d;
  logic [3:0]  badr_q, badr_d;
  logic        wrena_q, wrena_d;
  logic [3:0]  ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [3:0]  ovf_q, ovf_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;

  logic [1:0]  winner;
  logic [1:0]  idx;
  logic        found;
  logic        start;
  logic        hold_exit;
  logic [3:0]  clr;
  logic [3:0]  take;
  logic [3:0]  lost;

  // Control state is packed so one voter covers state, grant, pointer and pending.
  assign ctrl_d = {state_d, grant_d, ptr_d, pend_d};

  generate
    if (TMR != 0) begin : g_tmr
      logic [CW-1:0] copy_q [3];
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < 3; i++) copy_q[i] <= '0;
        end else begin
          for (int i = 0; i < 3; i++) copy_q[i] <= ctrl_d;
        end
      end
      assign ctrl_q = vote(copy_q[0], copy_q[1], copy_q[2]);
    end else begin : g_single
      logic [CW-1:0] copy_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) copy_q <= '0;
        else        copy_q <= ctrl_d;
      end
      assign ctrl_q = copy_q;
    end
  endgenerate

  assign state_q = state_e'(ctrl_q[9:8]);
  assign grant_q = ctrl_q[7:6];
  assign ptr_q   = ctrl_q[5:4];
  assign pend_q  = ctrl_q[3:0];

  // Round-robin scans from the pointer; fixed priority scans from A.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = (RR != 0) ? (ptr_q + 2'(k)) : 2'(k);
      if (!found && pend_q[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    setup_cnt_d = setup_cnt_q;
    start       = 1'b0;
    hold_exit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENA && (pend_q != 4'd0)) begin
          state_d     = SETUP;
          grant_d     = winner;
          ptr_d       = winner + 2'd1;
          setup_cnt_d = 2'd0;
          start       = 1'b1;
        end
      end
      SETUP: begin
        if (setup_cnt_q == 2'(SETUP_CYC - 1)) state_d = WRITE;
        else                                  setup_cnt_d = setup_cnt_q + 2'd1;
      end
      WRITE: state_d = HOLD;
      HOLD: begin
        state_d   = IDLE;
        hold_exit = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A request landing on the clearing edge is a fresh request, not an overflow.
    clr    = hold_exit ? onehot(grant_q) : 4'd0;
    take   = REQ & (~pend_q | clr);
    lost   = REQ & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | REQ;

    ovf_d = CNT_CLR ? 4'd0 : (ovf_q | lost);
    if (CNT_CLR)                             wr_cnt_d = 8'd0;
    else if (hold_exit && wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
    else                                     wr_cnt_d = wr_cnt_q;

    pathsel_d = (state_d == IDLE) ? 4'd0 : onehot(grant_d);
    if (state_d == IDLE) badr_d = 4'd0;
    else if (start)      badr_d = adr_q[winner];
    else                 badr_d = badr_q;
    wrena_d = (state_d == WRITE);
    ack_d   = (state_d == HOLD) ? onehot(grant_d) : 4'd0;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      setup_cnt_q <= 2'd0;
      pathsel_q   <= 4'd0;
      badr_q      <= 4'd0;
      wrena_q     <= 1'b0;
      ack_q       <= 4'd0;
      busy_q      <= 1'b0;
      ovf_q       <= 4'd0;
      wr_cnt_q    <= 8'd0;
    end else begin
      setup_cnt_q <= setup_cnt_d;
      pathsel_q   <= pathsel_d;
      badr_q      <= badr_d;
      wrena_q     <= wrena_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // Stored addresses are only meaningful while the matching pending flag is set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (take[i]) adr_q[i] <= REQ_ADR[4*i +: 4];
    end
  end

  assign PATHSEL = pathsel_q;
  assign BADR    = badr_q;
  assign WRENA   = wrena_q;
  assign ACK     = ack_q;
  assign PEND    = pend_q;
  assign BUSY    = busy_q;
  assign OVF     = ovf_q;
  assign WR_CNT  = wr_cnt_q;

endmodule

// File: tb/tb_sca_blk_sched.sv
// Directed bench for sca_blk_sched: main (RR, SETUP_CYC=1), fixed-priority TMR, SETUP_CYC=3.
module tb_sca_blk_sched;

  logic        CLK;
  logic        RST_N;
  logic        ENA;
  logic [3:0]  REQ;
  logic [15:0] REQ_ADR;
  logic        CNT_CLR;

  logic [3:0] m_pathsel, m_badr, m_ack, m_pend, m_ovf;
  logic       m_wrena, m_busy;
  logic [7:0] m_wr_cnt;
  logic [3:0] f_pathsel, f_badr, f_ack, f_pend, f_ovf;
  logic       f_wrena, f_busy;
  logic [7:0] f_wr_cnt;
  logic [3:0] s_pathsel, s_badr, s_ack, s_pend, s_ovf;
  logic       s_wrena, s_busy;
  logic [7:0] s_wr_cnt;

  int chk;
  int err;

  sca_blk_sched #(.RR(1), .SETUP_CYC(1), .TMR(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .REQ(REQ), .REQ_ADR(REQ_ADR), .CNT_CLR(CNT_CLR),
    .PATHSEL(m_pathsel), .BADR(m_badr), .WRENA(m_wrena), .ACK(m_ack), .PEND(m_pend),
    .BUSY(m_busy), .OVF(m_ovf), .WR_CNT(m_wr_cnt));

  sca_blk_sched #(.RR(0), .SETUP_CYC(1), .TMR(1)) dut_fp (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .REQ(REQ), .REQ_ADR(REQ_ADR), .CNT_CLR(CNT_CLR),
    .PATHSEL(f_pathsel), .BADR(f_badr), .WRENA(f_wrena), .ACK(f_ack), .PEND(f_pend),
    .BUSY(f_busy), .OVF(f_ovf), .WR_CNT(f_wr_cnt));

  sca_blk_sched #(.RR(1), .SETUP_CYC(3), .TMR(0)) dut_s3 (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .REQ(REQ), .REQ_ADR(REQ_ADR), .CNT_CLR(CNT_CLR),
    .PATHSEL(s_pathsel), .BADR(s_badr), .WRENA(s_wrena), .ACK(s_ack), .PEND(s_pend),
    .BUSY(s_busy), .OVF(s_ovf), .WR_CNT(s_wr_cnt));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    REQ = 4'd0; REQ_ADR = 16'd0; CNT_CLR = 1'b0; ENA = 1'b0;
    RST_N = 1'b0;
    tick; tick;
    RST_N = 1'b1;
  endtask

  task automatic test_reset;
    REQ = 4'd0; REQ_ADR = 16'd0; CNT_CLR = 1'b0; ENA = 1'b1;
    RST_N = 1'b0;
    #3;
    chk++; if ({m_pathsel, m_badr, m_wrena, m_ack, m_pend, m_busy, m_ovf, m_wr_cnt} !== 30'd0) begin
      err++; $display("FAIL reset_outputs: got %h exp 0",
                      {m_pathsel, m_badr, m_wrena, m_ack, m_pend, m_busy, m_ovf, m_wr_cnt}); end
    chk++; if ({f_pathsel, f_wrena, f_pend, f_busy, f_wr_cnt} !== 18'd0) begin
      err++; $display("FAIL reset_tmr: got %h exp 0", {f_pathsel, f_wrena, f_pend, f_busy, f_wr_cnt}); end
    tick;
    RST_N = 1'b1;
  endtask

  task automatic test_latency;
    do_reset;
    ENA = 1'b1; REQ = 4'b0001; REQ_ADR = 16'h0005;
    tick;  // E0
    REQ = 4'd0;
    chk++; if (m_pend !== 4'b0001 || m_pathsel !== 4'd0) begin
      err++; $display("FAIL lat_e0: got pend %b sel %b exp 0001 0000", m_pend, m_pathsel); end
    tick;  // E1
    chk++; if (m_pathsel !== 4'b0001 || m_badr !== 4'd5 || m_wrena !== 1'b0 || m_busy !== 1'b1) begin
      err++; $display("FAIL lat_e1: got sel %b badr %0d wr %b busy %b exp 0001 5 0 1",
                      m_pathsel, m_badr, m_wrena, m_busy); end
    chk++; if (f_pathsel !== 4'b0001 || f_badr !== 4'd5) begin
      err++; $display("FAIL lat_e1_tmr: got sel %b badr %0d exp 0001 5", f_pathsel, f_badr); end
    tick;  // E2
    chk++; if (m_wrena !== 1'b1 || m_ack !== 4'd0 || f_wrena !== 1'b1) begin
      err++; $display("FAIL lat_e2: got wr %b ack %b twr %b exp 1 0000 1", m_wrena, m_ack, f_wrena); end
    tick;  // E3
    chk++; if (m_wrena !== 1'b0 || m_ack !== 4'b0001 || m_pathsel !== 4'b0001 || f_ack !== 4'b0001) begin
      err++; $display("FAIL lat_e3: got wr %b ack %b sel %b tack %b exp 0 0001 0001 0001",
                      m_wrena, m_ack, m_pathsel, f_ack); end
    tick;  // E4
    chk++; if (m_ack !== 4'd0 || m_pathsel !== 4'd0 || m_badr !== 4'd0 || m_pend !== 4'd0 ||
               m_wr_cnt !== 8'd1 || m_busy !== 1'b0) begin
      err++; $display("FAIL lat_e4: got ack %b sel %b badr %0d pend %b cnt %0d busy %b exp all 0 cnt 1",
                      m_ack, m_pathsel, m_badr, m_pend, m_wr_cnt, m_busy); end
    chk++; if (f_wr_cnt !== 8'd1 || f_pend !== 4'd0) begin
      err++; $display("FAIL lat_e4_tmr: got cnt %0d pend %b exp 1 0000", f_wr_cnt, f_pend); end
  endtask

  task automatic test_round_robin;
    do_reset;
    ENA = 1'b1; REQ = 4'b1111; REQ_ADR = 16'h4321;
    tick;
    REQ = 4'd0;
    chk++; if (m_pend !== 4'b1111) begin
      err++; $display("FAIL rr_capture: got %b exp 1111", m_pend); end
    for (int k = 0; k < 4; k++) begin
      tick;
      chk++; if (m_pathsel !== 4'(1 << k) || m_badr !== 4'(k + 1)) begin
        err++; $display("FAIL rr_grant%0d: got sel %b badr %0d exp %b %0d",
                        k, m_pathsel, m_badr, 4'(1 << k), k + 1); end
      tick;
      chk++; if (m_wrena !== 1'b1) begin
        err++; $display("FAIL rr_wrena%0d: got %b exp 1", k, m_wrena); end
      tick;
      chk++; if (m_ack !== 4'(1 << k)) begin
        err++; $display("FAIL rr_ack%0d: got %b exp %b", k, m_ack, 4'(1 << k)); end
      tick;
      chk++; if (m_pathsel !== 4'd0 || m_busy !== 1'b0) begin
        err++; $display("FAIL rr_idle%0d: got sel %b busy %b exp 0000 0", k, m_pathsel, m_busy); end
    end
    chk++; if (m_wr_cnt !== 8'd4 || m_pend !== 4'd0 || m_ovf !== 4'd0) begin
      err++; $display("FAIL rr_final: got cnt %0d pend %b ovf %b exp 4 0000 0000", m_wr_cnt, m_pend, m_ovf); end
  endtask

  task automatic test_fixed_priority;
    do_reset;
    ENA = 1'b1; REQ = 4'b1111; REQ_ADR = 16'h4321;
    tick;
    REQ = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk++; if (f_pathsel !== 4'b0001 || f_badr !== ((k == 0) ? 4'd1 : 4'd5)) begin
        err++; $display("FAIL fp_grant%0d: got sel %b badr %0d exp 0001 %0d",
                        k, f_pathsel, f_badr, (k == 0) ? 1 : 5); end
      tick;
      tick;
      chk++; if (f_ack !== 4'b0001) begin
        err++; $display("FAIL fp_ack%0d: got %b exp 0001", k, f_ack); end
      REQ = 4'b0001; REQ_ADR = 16'h4325;
      tick;
      REQ = 4'd0;
    end
    chk++; if (f_pend !== 4'b1111 || f_ovf !== 4'd0 || f_wr_cnt !== 8'd3) begin
      err++; $display("FAIL fp_starve: got pend %b ovf %b cnt %0d exp 1111 0000 3", f_pend, f_ovf, f_wr_cnt); end
  endtask

  task automatic test_overflow;
    do_reset;
    ENA = 1'b0; REQ = 4'b0100; REQ_ADR = 16'h0700;
    tick;  // E0
    REQ = 4'd0;
    tick; tick;
    REQ = 4'b0100; REQ_ADR = 16'h0900;
    tick;  // E3
    REQ = 4'd0;
    chk++; if (m_ovf !== 4'b0100 || m_pend !== 4'b0100 || m_busy !== 1'b0) begin
      err++; $display("FAIL ovf_set: got ovf %b pend %b busy %b exp 0100 0100 0", m_ovf, m_pend, m_busy); end
    ENA = 1'b1;
    tick;
    chk++; if (m_pathsel !== 4'b0100 || m_badr !== 4'd7) begin
      err++; $display("FAIL ovf_first_adr: got sel %b badr %0d exp 0100 7", m_pathsel, m_badr); end
    tick; tick; tick;
    chk++; if (m_wr_cnt !== 8'd1 || m_ovf !== 4'b0100) begin
      err++; $display("FAIL ovf_sticky: got cnt %0d ovf %b exp 1 0100", m_wr_cnt, m_ovf); end
    CNT_CLR = 1'b1;
    tick;
    CNT_CLR = 1'b0;
    chk++; if (m_ovf !== 4'd0 || m_wr_cnt !== 8'd0) begin
      err++; $display("FAIL ovf_clear: got ovf %b cnt %0d exp 0000 0", m_ovf, m_wr_cnt); end
  endtask

  task automatic test_clear_edge_rereq;
    do_reset;
    ENA = 1'b1; REQ = 4'b0010; REQ_ADR = 16'h0030;
    tick;
    REQ = 4'd0;
    tick;
    chk++; if (m_pathsel !== 4'b0010 || m_badr !== 4'd3) begin
      err++; $display("FAIL clr_first: got sel %b badr %0d exp 0010 3", m_pathsel, m_badr); end
    tick; tick;
    REQ = 4'b0010; REQ_ADR = 16'h00A0;
    tick;  // HOLD exit edge
    REQ = 4'd0;
    chk++; if (m_ovf !== 4'd0 || m_pend !== 4'b0010 || m_pathsel !== 4'd0 || m_wr_cnt !== 8'd1) begin
      err++; $display("FAIL clr_edge: got ovf %b pend %b sel %b cnt %0d exp 0000 0010 0000 1",
                      m_ovf, m_pend, m_pathsel, m_wr_cnt); end
    tick;
    chk++; if (m_pathsel !== 4'b0010 || m_badr !== 4'hA) begin
      err++; $display("FAIL clr_second: got sel %b badr %h exp 0010 a", m_pathsel, m_badr); end
    tick; tick; tick;
    chk++; if (m_wr_cnt !== 8'd2 || m_pend !== 4'd0) begin
      err++; $display("FAIL clr_done: got cnt %0d pend %b exp 2 0000", m_wr_cnt, m_pend); end
  endtask

  task automatic test_ena_and_async_reset;
    do_reset;
    ENA = 1'b1; REQ = 4'b0011; REQ_ADR = 16'h0062;
    tick;
    REQ = 4'd0;
    tick;
    chk++; if (m_pathsel !== 4'b0001 || m_badr !== 4'd2) begin
      err++; $display("FAIL ena_start: got sel %b badr %0d exp 0001 2", m_pathsel, m_badr); end
    ENA = 1'b0;
    tick;
    chk++; if (m_wrena !== 1'b1) begin
      err++; $display("FAIL ena_write: got %b exp 1", m_wrena); end
    tick;
    chk++; if (m_ack !== 4'b0001) begin
      err++; $display("FAIL ena_ack: got %b exp 0001", m_ack); end
    tick; tick; tick;
    chk++; if (m_busy !== 1'b0 || m_pathsel !== 4'd0 || m_pend !== 4'b0010) begin
      err++; $display("FAIL ena_blocked: got busy %b sel %b pend %b exp 0 0000 0010", m_busy, m_pathsel, m_pend); end
    ENA = 1'b1;
    tick;
    chk++; if (m_pathsel !== 4'b0010 || m_badr !== 4'd6) begin
      err++; $display("FAIL ena_resume: got sel %b badr %0d exp 0010 6", m_pathsel, m_badr); end
    tick;
    chk++; if (m_wrena !== 1'b1) begin
      err++; $display("FAIL arst_pre: got wrena %b exp 1", m_wrena); end
    #1 RST_N = 1'b0;
    #1;
    chk++; if (m_wrena !== 1'b0 || m_pathsel !== 4'd0 || m_pend !== 4'd0 || m_busy !== 1'b0) begin
      err++; $display("FAIL arst_async: got wr %b sel %b pend %b busy %b exp 0 0000 0000 0",
                      m_wrena, m_pathsel, m_pend, m_busy); end
    tick;
    RST_N = 1'b1;
  endtask

  task automatic test_saturation;
    do_reset;
    ENA = 1'b1;
    for (int i = 0; i < 260; i++) begin
      REQ = 4'b0001; REQ_ADR = 16'h0001;
      tick;
      REQ = 4'd0;
      tick; tick; tick; tick;
      if (i == 0) begin
        chk++; if (m_wr_cnt !== 8'd1) begin
          err++; $display("FAIL sat_first: got %0d exp 1", m_wr_cnt); end
      end
      if (i == 253) begin
        chk++; if (m_wr_cnt !== 8'd254) begin
          err++; $display("FAIL sat_254: got %0d exp 254", m_wr_cnt); end
      end
    end
    chk++; if (m_wr_cnt !== 8'd255) begin
      err++; $display("FAIL sat_hold: got %0d exp 255", m_wr_cnt); end
    REQ = 4'b0001;
    tick;
    REQ = 4'd0;
    tick; tick; tick;
    CNT_CLR = 1'b1;
    tick;
    CNT_CLR = 1'b0;
    chk++; if (m_wr_cnt !== 8'd0 || m_pend !== 4'd0) begin
      err++; $display("FAIL sat_clr_priority: got cnt %0d pend %b exp 0 0000", m_wr_cnt, m_pend); end
  endtask

  task automatic test_setup_cyc3;
    do_reset;
    ENA = 1'b1; REQ = 4'b0001; REQ_ADR = 16'h0005;
    tick;  // E0
    REQ = 4'd0;
    tick;  // E1
    chk++; if (s_pathsel !== 4'b0001 || s_badr !== 4'd5 || s_wrena !== 1'b0) begin
      err++; $display("FAIL s3_sel: got sel %b badr %0d wr %b exp 0001 5 0", s_pathsel, s_badr, s_wrena); end
    tick; tick;  // E3
    chk++; if (s_wrena !== 1'b0 || s_pathsel !== 4'b0001) begin
      err++; $display("FAIL s3_early: got wr %b sel %b exp 0 0001", s_wrena, s_pathsel); end
    tick;  // E4
    chk++; if (s_wrena !== 1'b1) begin
      err++; $display("FAIL s3_wrena: got %b exp 1", s_wrena); end
    tick;  // E5
    chk++; if (s_wrena !== 1'b0 || s_ack !== 4'b0001) begin
      err++; $display("FAIL s3_ack: got wr %b ack %b exp 0 0001", s_wrena, s_ack); end
    tick;  // E6
    chk++; if (s_wr_cnt !== 8'd1 || s_busy !== 1'b0 || s_pathsel !== 4'd0) begin
      err++; $display("FAIL s3_done: got cnt %0d busy %b sel %b exp 1 0 0000", s_wr_cnt, s_busy, s_pathsel); end
  endtask

  initial begin
    chk = 0;
    err = 0;
    RST_N = 1'b1; ENA = 1'b0; REQ = 4'd0; REQ_ADR = 16'd0; CNT_CLR = 1'b0;
    test_reset;
    test_latency;
    test_round_robin;
    test_fixed_priority;
    test_overflow;
    test_clear_edge_rereq;
    test_ena_and_async_reset;
    test_saturation;
    test_setup_cyc3;
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
